vga_fault_manager: RTL

//  Consumes the MISMATCH flag from the dual-VGA lockstep comparator and turns it into a managed fault.

---
 rtl/vga_fault_manager.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vga_fault_manager.sv
// Lockstep mismatch fault manager: glitch filter, sticky FAULT, saturating event count, IRQ/blank, AHB-Lite regs.
// Optional VGA_FAULT_TSTAMP_EN builds the free-running cycle counter and the TSTAMP register.
module vga_fault_manager #(
  parameter int FILTER_CYCLES = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        MISMATCH,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        FAULT_IRQ,
  output logic        BLANK,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_OK     = 2'd0,
    ST_FILTER = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [7:0]           filt_cnt, filt_nxt;
  logic                 evt;
  logic                 active;
  logic                 fault;
  logic [CNT_WIDTH-1:0] count;
  logic [1:0]           ctrl;
  logic                 dp_valid;
  logic                 dp_write;
  logic [1:0]           dp_addr;
  logic                 wr_ctrl;
  logic                 wr_clear;
  logic [31:0]          tstamp_rd;
  logic                 unused_bits;

  // FSM state register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_OK;
      filt_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      filt_cnt <= filt_nxt;
    end
  end

  // FSM next state; evt marks the cycle whose edge registers a new fault event
  always_comb begin
    state_nxt = state;
    filt_nxt  = filt_cnt;
    evt       = 1'b0;
    case (state)
      ST_OK: begin
        if (MISMATCH) begin
          if (FILTER_CYCLES == 1) begin
            state_nxt = ST_ACTIVE;
            filt_nxt  = 8'd0;
            evt       = 1'b1;
          end else begin
            state_nxt = ST_FILTER;
            filt_nxt  = 8'd1;
          end
        end
      end
      ST_FILTER: begin
        if (!MISMATCH) begin
          state_nxt = ST_OK;
          filt_nxt  = 8'd0;
        end else if (({1'b0, filt_cnt} + 9'd1) == 9'(FILTER_CYCLES)) begin
          state_nxt = ST_ACTIVE;
          filt_nxt  = 8'd0;
          evt       = 1'b1;
        end else begin
          filt_nxt = filt_cnt + 8'd1;
        end
      end
      ST_ACTIVE: begin
        if (!MISMATCH) begin
          state_nxt = ST_OK;
          filt_nxt  = 8'd0;
        end
      end
      default: begin
        state_nxt = ST_OK;
        filt_nxt  = 8'd0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    active    = (state == ST_ACTIVE);
    dbg_state = state;
  end

  // AHB handshake: an address phase is taken when HSEL & HREADY & HTRANS[1];
  // the following cycle is its data phase, and HREADYOUT is always 1 (no wait states, no errors).
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'd0;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:2];
    end
  end

  assign wr_ctrl  = dp_valid & dp_write & (dp_addr == 2'd1);
  assign wr_clear = dp_valid & dp_write & (dp_addr == 2'd2) & HWDATA[0];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl <= 2'd0;
    end else if (wr_ctrl) begin
      ctrl <= HWDATA[1:0];
    end
  end

  // An event in the same cycle as CLEAR wins and restarts the count at 1
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      fault <= 1'b0;
      count <= '0;
    end else if (evt) begin
      fault <= 1'b1;
      if (wr_clear)    count <= CNT_WIDTH'(1);
      else if (~&count) count <= count + CNT_WIDTH'(1);
    end else if (wr_clear) begin
      fault <= 1'b0;
      count <= '0;
    end
  end

`ifdef VGA_FAULT_TSTAMP_EN
  logic [31:0] cyc;
  logic [31:0] tstamp;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cyc    <= 32'd0;
      tstamp <= 32'd0;
    end else begin
      cyc <= cyc + 32'd1;
      if (evt && (!fault || wr_clear)) tstamp <= cyc;
      else if (wr_clear)               tstamp <= 32'd0;
    end
  end

  assign tstamp_rd = tstamp;
`else
  assign tstamp_rd = 32'd0;
`endif

  always_comb begin
    HRDATA = 32'd0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        2'd0:    HRDATA = {16'(count), 14'd0, active, fault};
        2'd1:    HRDATA = {30'd0, ctrl};
        2'd3:    HRDATA = tstamp_rd;
        default: HRDATA = 32'd0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign FAULT_IRQ = fault & ctrl[0];
  assign BLANK     = fault & ctrl[1];

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:2]};

endmodule
